// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the cache/memory arbiter
//
// Purpose: default widths, FSM state encoding and owner encoding shared by
// cache_mem_arbiter and arb_pick.
// Ports: none (package).
// Configuration: ARB_ROUND_ROBIN_EN (see arb_pick) selects round-robin picking.

package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - two-way combinational owner picker
//
// Purpose: choose which cache owns the next memory transaction.
// Ports:
//   d_req       in   dcache has a read or write pending
//   i_req       in   icache has a read pending
//   last_owner  in   owner of the previous grant (OWN_D / OWN_I)
//   grant_owner out  owner to grant when at least one request is pending
// Configuration: ARB_ROUND_ROBIN_EN defined -> alternate on ties;
//   undefined -> fixed dcache priority.

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic d_req,
  input  logic i_req,
  input  logic last_owner,
  output logic grant_owner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_owner = OWN_D;
    if (d_req && i_req) begin
      grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req) begin
      grant_owner = OWN_I;
    end
  end
`else
  // Fixed priority never looks at history.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_owner = OWN_D;
    if (i_req && !d_req) begin
      grant_owner = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one block-wide memory port between icache and dcache
//
// Purpose: grants the memory port to one cache at a time, registers the
// memory strobes/address/data, waits for the memory, returns the read block
// and inserts a one-cycle strobe-low DONE gap after every access.
// Ports:
//   CLOCK, RESET                     clock, async active-low reset
//   D_READ/D_WRITE/D_ADDRESS/D_WRITEDATA   dcache request
//   D_READDATA, D_BUSYWAIT           dcache response / stall
//   I_READ/I_ADDRESS                 icache request
//   I_READDATA, I_BUSYWAIT           icache response / stall
//   MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA  registered memory request
//   MEM_READDATA, MEM_BUSYWAIT       memory response
// Configuration: ARB_ROUND_ROBIN_EN enables round-robin arbitration on ties.

module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic               armed_q, armed_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;

  logic d_req;
  logic i_req;
  logic grant_owner;

  assign d_req = D_READ | D_WRITE;
  assign i_req = I_READ;

  arb_pick u_arb_pick (
    .d_req       (d_req),
    .i_req       (i_req),
    .last_owner  (last_owner_q),
    .grant_owner (grant_owner)
  );

  // Stall is released only in the owner's DONE cycle; no request, no stall.
  assign D_BUSYWAIT = d_req & ~((state_q == ST_DONE) & (owner_q == OWN_D));
  assign I_BUSYWAIT = i_req & ~((state_q == ST_DONE) & (owner_q == OWN_I));

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign D_READDATA    = d_rdata_q;
  assign I_READDATA    = i_rdata_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    armed_d      = armed_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;

    case (state_q)
      ST_IDLE: begin
        armed_d = 1'b0;
        if (d_req || i_req) begin
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          state_d      = ST_ACCESS;
          if (grant_owner == OWN_D) begin
            // Read+write together is a write-back; never strobe both.
            mem_read_d  = D_READ & ~D_WRITE;
            mem_write_d = D_WRITE;
            mem_addr_d  = D_ADDRESS;
            mem_wdata_d = D_WRITEDATA;
          end else begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = I_ADDRESS;
          end
        end
      end

      ST_ACCESS: begin
        // The memory needs one edge to see the strobe and raise its own
        // busywait, so the first edge in ACCESS only arms the exit check.
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (!MEM_BUSYWAIT) begin
          if (mem_read_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = MEM_READDATA;
            end else begin
              i_rdata_d = MEM_READDATA;
            end
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_D;
      last_owner_q <= OWN_I;
      armed_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      armed_q      <= armed_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter

module tb_cache_mem_arbiter;

  localparam int AW  = 28;
  localparam int BW  = 128;
  localparam int LAT = 2;

  logic          CLOCK;
  logic          RESET;
  logic          D_READ, D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [BW-1:0] D_WRITEDATA, D_READDATA;
  logic          D_BUSYWAIT;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [BW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          MEM_READ, MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [BW-1:0] MEM_WRITEDATA, MEM_READDATA;
  logic          MEM_BUSYWAIT;

  cache_mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: busy while strobed until LAT edges have passed.
  logic [BW-1:0] mem [0:31];
  int mcnt = 0;
  assign MEM_READDATA = mem[MEM_ADDRESS[4:0]];
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt != LAT);
  always @(posedge CLOCK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (mcnt == LAT) begin
        mcnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS[4:0]] <= MEM_WRITEDATA;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Scoreboard of expected memory transactions {write, address}.
  logic [AW:0] exp_q[$];
  logic [AW:0] exp_e;
  logic        prev_strobe = 1'b0;
  int          low_cnt = 0;
  bit          seen_any = 1'b0;

  task automatic push_mem(input logic wr, input logic [AW-1:0] a);
    exp_q.push_back({wr, a});
  endtask

  always @(negedge CLOCK) begin
    if ((MEM_READ | MEM_WRITE) && !prev_strobe) begin
      check_eq("mem_rw_excl", {127'd0, MEM_READ & MEM_WRITE}, 0);
      check_eq("sb_pending", {127'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check_eq("mem_txn", {{(BW-AW-1){1'b0}}, MEM_WRITE, MEM_ADDRESS},
                 {{(BW-AW-1){1'b0}}, exp_e});
      end
      if (seen_any) check_eq("strobe_gap", {127'd0, low_cnt >= 1}, 1);
      seen_any = 1'b1;
    end
    if (MEM_READ | MEM_WRITE) low_cnt = 0;
    else low_cnt++;
    prev_strobe = MEM_READ | MEM_WRITE;
  end

  task automatic wait_d_done(output int w);
    w = 0;
    @(negedge CLOCK);
    while (D_BUSYWAIT && w < 50) begin
      w++;
      @(negedge CLOCK);
    end
    if (w >= 50) check_eq("d_timeout", w, 0);
  endtask

  task automatic d_access(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                          input logic [BW-1:0] exp_rd, input int exp_wait);
    logic [BW-1:0] old;
    int w;
    old         = D_READDATA;
    D_READ      = !wr;
    D_WRITE     = wr;
    D_ADDRESS   = a;
    D_WRITEDATA = wd;
    wait_d_done(w);
    if (w < 50) begin
      if (exp_wait >= 0) check_eq("d_latency", w, exp_wait);
      if (wr) check_eq("d_rdata_hold_on_write", D_READDATA, old);
      else    check_eq("d_rdata", D_READDATA, exp_rd);
      check_eq("d_strobe_low_done", {127'd0, MEM_READ | MEM_WRITE}, 0);
      if (I_READ) check_eq("i_bw_during_d", {127'd0, I_BUSYWAIT}, 1);
    end
    @(posedge CLOCK); #1;
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
  endtask

  task automatic i_access(input logic [AW-1:0] a, input logic [BW-1:0] exp_rd);
    int w;
    I_READ    = 1'b1;
    I_ADDRESS = a;
    w = 0;
    @(negedge CLOCK);
    while (I_BUSYWAIT && w < 50) begin
      w++;
      @(negedge CLOCK);
    end
    if (w >= 50) check_eq("i_timeout", w, 0);
    else begin
      check_eq("i_rdata", I_READDATA, exp_rd);
      check_eq("i_strobe_low_done", {127'd0, MEM_READ | MEM_WRITE}, 0);
      if (D_READ | D_WRITE) check_eq("d_bw_during_i", {127'd0, D_BUSYWAIT}, 1);
    end
    @(posedge CLOCK); #1;
    I_READ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int k;
    for (int i = 0; i < 32; i++) mem[i] = {4{32'h1000_0000 + i * 32'h0101_0101}};
    mem[16] = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    RESET = 1'b0; D_READ = 0; D_WRITE = 0; D_ADDRESS = '0; D_WRITEDATA = '0;
    I_READ = 0; I_ADDRESS = '0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    check_eq("rst_mem_read", {127'd0, MEM_READ}, 0);
    check_eq("rst_mem_write", {127'd0, MEM_WRITE}, 0);
    check_eq("rst_mem_addr", {100'd0, MEM_ADDRESS}, 0);
    check_eq("rst_mem_wdata", MEM_WRITEDATA, 0);
    check_eq("rst_d_rdata", D_READDATA, 0);
    check_eq("rst_i_rdata", I_READDATA, 0);
    check_eq("rst_busy", {126'd0, D_BUSYWAIT, I_BUSYWAIT}, 0);
    @(posedge CLOCK); #1;
    RESET = 1'b1;

    // Paired D/I reads right after reset: D, I in every pair.
    for (int p = 0; p < 4; p++) begin
      push_mem(1'b0, 28'h5);
      push_mem(1'b0, 28'h9);
      @(posedge CLOCK); #1;
      fork
        d_access(1'b0, 28'h5, '0, mem[5], -1);
        i_access(28'h9, mem[9]);
      join
    end

    // Held dcache read at 0x10: latency, 1-cycle BUSYWAIT drop, re-grant.
    push_mem(1'b0, 28'h10);
    push_mem(1'b0, 28'h10);
    @(posedge CLOCK); #1;
    D_READ = 1'b1; D_ADDRESS = 28'h10;
    wait_d_done(w);
    check_eq("d_latency_first", w, 4);
    check_eq("d_rdata_0x10", D_READDATA, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check_eq("mem_read_low_done", {127'd0, MEM_READ}, 0);
    @(negedge CLOCK);
    check_eq("d_bw_one_cycle", {127'd0, D_BUSYWAIT}, 1);
    wait_d_done(w);
    check_eq("d_rdata_0x10_again", D_READDATA, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(posedge CLOCK); #1;
    D_READ = 1'b0;

    // Last grant was D: a tie now goes to I only under round-robin.
`ifdef ARB_ROUND_ROBIN_EN
    push_mem(1'b0, 28'h9);
    push_mem(1'b0, 28'h5);
`else
    push_mem(1'b0, 28'h5);
    push_mem(1'b0, 28'h9);
`endif
    @(posedge CLOCK); #1;
    fork
      d_access(1'b0, 28'h5, '0, mem[5], -1);
      i_access(28'h9, mem[9]);
    join

    // Write-back then read of the same block.
    push_mem(1'b1, 28'h3);
    push_mem(1'b0, 28'h3);
    @(posedge CLOCK); #1;
    d_access(1'b1, 28'h3, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, '0, 4);
    @(posedge CLOCK); #1;
    d_access(1'b0, 28'h3, '0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 4);

    // icache request withdrawn one cycle after grant; dcache served next.
    push_mem(1'b0, 28'h7);
    push_mem(1'b0, 28'hA);
    @(posedge CLOCK); #1;
    I_READ = 1'b1; I_ADDRESS = 28'h7;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    I_READ = 1'b0;
    d_access(1'b0, 28'hA, '0, mem[10], -1);
    check_eq("i_rdata_withdrawn", I_READDATA, mem[7]);
    check_eq("i_bw_no_req", {127'd0, I_BUSYWAIT}, 0);

    // Reset asserted in the middle of an access.
    push_mem(1'b0, 28'h4);
    @(posedge CLOCK); #1;
    D_READ = 1'b1; D_ADDRESS = 28'h4;
    k = 0;
    @(negedge CLOCK);
    while (!MEM_READ && k < 20) begin
      k++;
      @(negedge CLOCK);
    end
    check_eq("rst_mid_strobe_seen", {127'd0, MEM_READ}, 1);
    #2;
    RESET = 1'b0;
    #1;
    check_eq("rst_async_mem_read", {127'd0, MEM_READ}, 0);
    check_eq("rst_async_mem_write", {127'd0, MEM_WRITE}, 0);
    check_eq("rst_async_d_rdata", D_READDATA, 0);
    check_eq("rst_async_i_rdata", I_READDATA, 0);
    D_READ = 1'b0;
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    push_mem(1'b0, 28'h6);
    @(posedge CLOCK); #1;
    d_access(1'b0, 28'h6, '0, mem[6], 4);

    repeat (3) @(posedge CLOCK);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
